log_dump_streamer: RTL
======================

// Module: log_dump_streamer
// PURPOSE
//  Downstream consumer of the trace-log BRAM: on a host command, reads N logged 24-bit
//  entries through the BRAM read port and streams them as a framed byte sequence to the
//  UART TX byte interface. Optionally re-arms logging (log-pointer clear) after the dump.
//  Sits between the UART command decoder and the log BRAM / UART transmitter, in the BRAM clock domain.
// PARAMETERS
//  ADDR_WIDTH   10     log BRAM address width; DEPTH = 2**ADDR_WIDTH, must be <= 15
//  HEADER_BYTE  8'hA5  frame start marker
// PORTS
//  clk             in   1             system clock (BRAM port clock)
//  rst             in   1             asynchronous reset, active-high
//  start           in   1             1-cycle command pulse; ignored while busy
//  count           in   ADDR_WIDTH+1  entries to dump, sampled on accepted start
//  clear_after     in   1             sampled with start; request log_clear at end of frame
//  abort           in   1             terminate frame immediately
//  busy            out  1             frame in progress
//  done            out  1             1-cycle pulse: frame complete (not asserted on abort)
//  mem_rd          out  1             1-cycle BRAM read request
//  mem_addr        out  ADDR_WIDTH    BRAM read address, valid with mem_rd
//  mem_data        in   24            BRAM read data {type[7:0], addr[15:0]}
//  mem_data_valid  in   1             read data strobe (2 cycles after mem_rd)
//  tx_data         out  8             byte to UART TX
//  tx_valid        out  1             byte valid
//  tx_ready        in   1             TX accepts byte when tx_valid & tx_ready
//  log_clear       out  1             1-cycle pulse to the log writer pointer reset (trigger_init)
// BEHAVIOUR
//  - Reset: busy=0 done=0 mem_rd=0 mem_addr=0 tx_valid=0 tx_data=0 log_clear=0; FSM IDLE.
//  - Frame: HEADER_BYTE, CNT_HI, CNT_LO, then per entry bytes [23:16],[15:8],[7:0],
//    then CSUM = XOR of every preceding byte of the frame incl. header.
//  - count clamped to DEPTH; clamped value is what appears in CNT field (16-bit, zero-extended).
//  - FSM: IDLE -> HDR -> CNT_HI -> CNT_LO -> (RD_REQ -> RD_WAIT -> B2 -> B1 -> B0)*N -> CSUM -> IDLE.
//    count=0 goes CNT_LO -> CSUM directly.
//  - Byte handshake: tx_valid asserted with tx_data stable until accepted; next byte may be
//    presented the cycle after acceptance (no combinational ready->valid path). Max 1 byte/2 cycles acceptable.
//  - RD_REQ: mem_rd high exactly 1 cycle, mem_addr = entry index (0..N-1, ascending).
//    RD_WAIT: hold until mem_data_valid; latch mem_data into 24-bit holding reg. Exactly one
//    mem_rd per entry regardless of TX backpressure; next read issued only after B0 accepted.
//  - mem_data_valid outside RD_WAIT ignored.
//  - Entry counter ADDR_WIDTH+1 bits; no wrap: last address DEPTH-1 when count=DEPTH.
//  - busy high from cycle after accepted start through cycle CSUM accepted.
//  - On CSUM acceptance: next cycle done=1, busy=0, and log_clear=1 iff clear_after was latched.
//  - start while busy: ignored, no effect on latched count/clear_after.
//  - start and abort same cycle in IDLE: start ignored.
//  - abort while busy: next cycle tx_valid=0, mem_rd=0, busy=0, FSM IDLE; no done, no log_clear;
//    a pending BRAM read response is discarded. Partial frame is host's responsibility (no CSUM).
//  - rst mid-frame: all outputs to reset values asynchronously; no log_clear.
// STRUCTURE
//  - Shared package (log_pkg): LOG_ENTRY_W=24, LOG_HEADER_BYTE=8'hA5, FSM state encoding enum,
//    log entry field offsets (type [23:16], addr [15:0]).
//  - One sub-module natural: log_byte_tx_slot - single-entry output register implementing
//    valid/ready hold and running XOR checksum (clear on frame start).
//  - Top holds FSM, entry counter, read request/holding register.
// TESTING
//  1. mem[0]=24'h123456, mem[1]=24'hABCDEF, start count=2, tx_ready=1 -> bytes A5 00 02 12 34 56
//     AB CD EF 5E; done 1 pulse; exactly 2 mem_rd at addr 0,1; log_clear=0.
//  2. start count=0 -> A5 00 00 A5; no mem_rd; done pulse.
//  3. Scenario 1 with random tx_ready (~30% duty) -> identical byte sequence, tx_data stable while
//     valid&!ready, still exactly 2 mem_rd.
//  4. count=DEPTH+1 (ADDR_WIDTH=4: count=17) clear_after=1 -> CNT bytes 00 10, 16 entries addr 0..15,
//     log_clear pulse coincident with done.
//  5. abort while in B1 of entry 3, then start count=1 -> tx_valid low next cycle, no done/log_clear;
//     new frame correct from A5; late mem_data_valid from aborted read ignored.
//  6. start during busy, and rst asserted mid-RD_WAIT -> start ignored; on rst all outputs reset
//     immediately, next start yields a clean frame.

Source files
------------

// File: rtl/log_pkg.sv
// -----------------------------------------------------------------------------
// log_pkg
// Shared definitions for the trace-log dump path.
//   LOG_ENTRY_W      width of one logged entry {type[7:0], addr[15:0]}
//   LOG_HEADER_BYTE  default frame start marker
//   LOG_TYPE_*       bit offsets of the type field inside an entry
//   LOG_ADDR_*       bit offsets of the address field inside an entry
//   log_state_e      dump streamer FSM state encoding
// -----------------------------------------------------------------------------
package log_pkg;

  localparam int         LOG_ENTRY_W     = 24;
  localparam logic [7:0] LOG_HEADER_BYTE = 8'hA5;

  localparam int LOG_TYPE_MSB = 23;
  localparam int LOG_TYPE_LSB = 16;
  localparam int LOG_ADDR_MSB = 15;
  localparam int LOG_ADDR_LSB = 0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_B2,
    ST_B1,
    ST_B0,
    ST_CSUM
  } log_state_e;

endpackage

// File: rtl/log_byte_tx_slot.sv
// -----------------------------------------------------------------------------
// log_byte_tx_slot
// Single-entry output register towards the UART transmitter. Holds a byte with
// tx_valid until the transmitter takes it, and keeps a running XOR of every
// byte loaded since the last clear so the frame checksum is always at hand.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clear_i       restart the running checksum (frame start)
//   flush_i       drop the held byte immediately (frame abort)
//   load_i        capture data_i as the next byte; only issued while empty
//   data_i        byte to present
//   tx_ready_i    transmitter ready
//   tx_data_o     byte presented to the transmitter
//   tx_valid_o    byte valid
//   accept_o      handshake completes this cycle
//   csum_o        XOR of all bytes loaded since clear
// -----------------------------------------------------------------------------
module log_byte_tx_slot
  import log_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       flush_i,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       tx_ready_i,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  output logic       accept_o,
  output logic [7:0] csum_o
);

  logic [7:0] data_q, data_d;
  logic [7:0] csum_q, csum_d;
  logic       valid_q, valid_d;

  assign accept_o   = valid_q & tx_ready_i;
  assign tx_data_o  = data_q;
  assign tx_valid_o = valid_q;
  assign csum_o     = csum_q;

  // Flush beats a load so an abort can never leave a byte on the bus.
  // The checksum folds a byte in at load time, so it is complete as soon
  // as the last payload byte has been loaded.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    csum_d  = csum_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (accept_o) begin
      valid_d = 1'b0;
    end
    if (clear_i) begin
      csum_d = 8'h00;
    end
    if (load_i && !flush_i) begin
      csum_d = csum_d ^ data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      csum_q  <= 8'h00;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      csum_q  <= csum_d;
    end
  end

endmodule

// File: rtl/log_dump_streamer.sv
// -----------------------------------------------------------------------------
// log_dump_streamer
// On a host command, reads N entries from the trace-log BRAM and streams them
// to the UART transmitter as: HEADER, CNT_HI, CNT_LO, {B2,B1,B0}*N, CSUM,
// where CSUM is the XOR of all preceding frame bytes. Optionally pulses
// log_clear at the end of a completed frame to re-arm logging.
// Ports:
//   clk, rst            BRAM clock, asynchronous active-high reset
//   start_i             command pulse, ignored while busy or with abort_i
//   count_i             entries to dump, clamped to DEPTH
//   clear_after_i       request log_clear when the frame completes
//   abort_i             stop the frame at once (no checksum, no done)
//   busy_o              frame in progress
//   done_o              one-cycle pulse after the checksum byte is taken
//   mem_rd_o/mem_addr_o BRAM read request and address
//   mem_data_i          BRAM read data {type, addr}
//   mem_data_valid_i    BRAM read data strobe
//   tx_data_o/tx_valid_o/tx_ready_i  byte stream to the UART transmitter
//   log_clear_o         one-cycle pulse to reset the log writer pointer
// -----------------------------------------------------------------------------
module log_dump_streamer
  import log_pkg::*;
#(
  parameter int         ADDR_WIDTH  = 10,
  parameter logic [7:0] HEADER_BYTE = LOG_HEADER_BYTE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [ADDR_WIDTH:0]    count_i,
  input  logic                   clear_after_i,
  input  logic                   abort_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   mem_rd_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  input  logic [LOG_ENTRY_W-1:0] mem_data_i,
  input  logic                   mem_data_valid_i,
  output logic [7:0]             tx_data_o,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i,
  output logic                   log_clear_o
);

  localparam logic [ADDR_WIDTH:0] DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ENTRY_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  log_state_e             state_q;
  logic [ADDR_WIDTH:0]    count_q;
  logic [ADDR_WIDTH:0]    entry_q;
  logic [ADDR_WIDTH:0]    entry_next;
  logic [ADDR_WIDTH:0]    count_clamped;
  logic                   clear_after_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   mem_rd_q;
  logic [ADDR_WIDTH-1:0]  mem_addr_q;
  logic                   log_clear_q;
  logic [LOG_ENTRY_W-1:0] hold_q;
  logic [15:0]            cnt_field;

  logic                   frame_start;
  logic                   frame_abort;
  logic                   byte_load;
  logic [7:0]             byte_data;
  logic                   byte_accept;
  logic                   tx_valid;
  logic [7:0]             csum;

  assign frame_start   = (state_q == ST_IDLE) && start_i && !abort_i;
  assign frame_abort   = (state_q != ST_IDLE) && abort_i;
  assign count_clamped = (count_i > DEPTH) ? DEPTH : count_i;
  assign entry_next    = entry_q + ENTRY_ONE;
  assign cnt_field     = 16'(count_q);

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign mem_rd_o    = mem_rd_q;
  assign mem_addr_o  = mem_addr_q;
  assign log_clear_o = log_clear_q;
  assign tx_valid_o  = tx_valid;

  // Every byte-emitting state loads its byte once the slot is empty and moves
  // on when that byte is accepted. This leaves one idle cycle between bytes,
  // which keeps tx_ready out of any path to tx_valid.
  always_comb begin
    byte_load = 1'b0;
    byte_data = 8'h00;
    if (!abort_i && !tx_valid) begin
      byte_load = 1'b1;
      case (state_q)
        ST_HDR:    byte_data = HEADER_BYTE;
        ST_CNT_HI: byte_data = cnt_field[15:8];
        ST_CNT_LO: byte_data = cnt_field[7:0];
        ST_B2:     byte_data = hold_q[LOG_TYPE_MSB:LOG_TYPE_LSB];
        ST_B1:     byte_data = hold_q[LOG_ADDR_MSB:8];
        ST_B0:     byte_data = hold_q[7:LOG_ADDR_LSB];
        ST_CSUM:   byte_data = csum;
        default:   byte_load = 1'b0;
      endcase
    end
  end

  log_byte_tx_slot u_slot (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (frame_start),
    .flush_i    (frame_abort),
    .load_i     (byte_load),
    .data_i     (byte_data),
    .tx_ready_i (tx_ready_i),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid),
    .accept_o   (byte_accept),
    .csum_o     (csum)
  );

  // Frame sequencer. mem_rd is raised on entry to RD_REQ so it is high for
  // exactly the RD_REQ cycle; the next read is only requested after B0 of
  // the previous entry has been accepted, so backpressure never causes an
  // extra read. Abort overrides everything and discards any pending response
  // simply by leaving RD_WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      entry_q       <= '0;
      clear_after_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mem_rd_q      <= 1'b0;
      mem_addr_q    <= '0;
      log_clear_q   <= 1'b0;
      hold_q        <= '0;
    end else begin
      done_q      <= 1'b0;
      log_clear_q <= 1'b0;
      mem_rd_q    <= 1'b0;
      if (frame_abort) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (frame_start) begin
              count_q       <= count_clamped;
              clear_after_q <= clear_after_i;
              entry_q       <= '0;
              busy_q        <= 1'b1;
              state_q       <= ST_HDR;
            end
          end
          ST_HDR: begin
            if (byte_accept) state_q <= ST_CNT_HI;
          end
          ST_CNT_HI: begin
            if (byte_accept) state_q <= ST_CNT_LO;
          end
          ST_CNT_LO: begin
            if (byte_accept) begin
              if (count_q == '0) begin
                state_q <= ST_CSUM;
              end else begin
                state_q    <= ST_RD_REQ;
                mem_rd_q   <= 1'b1;
                mem_addr_q <= entry_q[ADDR_WIDTH-1:0];
              end
            end
          end
          ST_RD_REQ: begin
            state_q <= ST_RD_WAIT;
          end
          ST_RD_WAIT: begin
            if (mem_data_valid_i) begin
              hold_q  <= mem_data_i;
              state_q <= ST_B2;
            end
          end
          ST_B2: begin
            if (byte_accept) state_q <= ST_B1;
          end
          ST_B1: begin
            if (byte_accept) state_q <= ST_B0;
          end
          ST_B0: begin
            if (byte_accept) begin
              if (entry_next == count_q) begin
                state_q <= ST_CSUM;
              end else begin
                entry_q    <= entry_next;
                state_q    <= ST_RD_REQ;
                mem_rd_q   <= 1'b1;
                mem_addr_q <= entry_next[ADDR_WIDTH-1:0];
              end
            end
          end
          ST_CSUM: begin
            if (byte_accept) begin
              state_q     <= ST_IDLE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              log_clear_q <= clear_after_q;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
